// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared definitions for the store buffer that sits between the EX/MEM
// pipeline register and the data memory.
//   SB_DEPTH / SB_AW / SB_DW : default buffer depth, address and data widths
//   WORD_BYTES               : bytes per memory word (the buffer never splits words)
//   sb_entry_t               : one buffered store {addr, data}
//   sb_port_e                : who owns the data-memory port this cycle
// -----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int SB_DEPTH   = 4;
    localparam int SB_AW      = 32;
    localparam int SB_DW      = 32;
    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_LOAD,
        PORT_DRAIN,
        PORT_FORCED_DRAIN
    } sb_port_e;

endpackage

// File: rtl/sb_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
// Circular FIFO holding pending stores. Every entry and a valid mask are
// exposed so the parent can run the load-forwarding compare across the whole
// buffer.
//   clk      : clock
//   i_clr    : synchronous clear (discards pending stores)
//   i_enq    : write {i_addr, i_data} at tail
//   i_deq    : retire the head entry
//   o_addr   : all entry addresses
//   o_data   : all entry data words
//   o_valid  : per-slot valid mask
//   o_head   : head (oldest) slot index
//   o_count  : number of pending entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                          clk,
    input  logic                          i_clr,
    input  logic                          i_enq,
    input  logic                          i_deq,
    input  logic [AW-1:0]                 i_addr,
    input  logic [DW-1:0]                 i_data,
    output logic [DEPTH-1:0][AW-1:0]      o_addr,
    output logic [DEPTH-1:0][DW-1:0]      o_data,
    output logic [DEPTH-1:0]              o_valid,
    output logic [$clog2(DEPTH)-1:0]      o_head,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] r_addr;
    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [CW-1:0]            r_count;
    logic [PW-1:0]            w_off;

    // DEPTH is a power of two, so pointer wrap is plain PW-bit overflow.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_enq) begin
                r_addr[r_tail] <= i_addr;
                r_data[r_tail] <= i_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (i_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is valid when its distance from head is below the count.
    always_comb begin
        o_valid = '0;
        w_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = PW'(i) - r_head;
            o_valid[i] = {1'b0, w_off} < r_count;
        end
    end

    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Write buffer between EX/MEM and the data memory. Stores are queued and
// drained when the memory port is otherwise idle (or forced when full);
// loads are served from the youngest matching buffered store, else from
// memory. The load result is held on ReadData while no load is active.
//   clk, startin          : clock, synchronous active-high reset
//   Address, WriteData    : CPU word address / store data
//   MemWrite, MemRead     : store / load request
//   ReadData              : load result (held between loads)
//   Stall                 : store refused this cycle (buffer full)
//   Empty, Count          : buffer occupancy
//   mem_*                 : data-memory port (combinational read data)
// -----------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     startin,
    input  logic [AW-1:0]            Address,
    input  logic [DW-1:0]            WriteData,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    output logic [DW-1:0]            ReadData,
    output logic                     Stall,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [AW-1:0]            mem_Address,
    output logic [DW-1:0]            mem_WriteData,
    output logic                     mem_MemWrite,
    output logic                     mem_MemRead,
    input  logic [DW-1:0]            mem_ReadData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OB = $clog2(WORD_BYTES);

    logic [DEPTH-1:0][AW-1:0] w_ent_addr;
    logic [DEPTH-1:0][DW-1:0] w_ent_data;
    logic [DEPTH-1:0]         w_valid;
    logic [PW-1:0]            w_head;
    logic [CW-1:0]            w_count;
    logic [PW-1:0]            w_idx;
    logic                     w_full;
    logic                     w_enq;
    logic                     w_deq;
    logic                     w_hit;
    logic [DW-1:0]            w_fwd;
    logic [DW-1:0]            w_load_data;
    sb_port_e                 w_port;
    logic [DW-1:0]            r_hold;

    sb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk     (clk),
        .i_clr   (startin),
        .i_enq   (w_enq),
        .i_deq   (w_deq),
        .i_addr  (Address),
        .i_data  (WriteData),
        .o_addr  (w_ent_addr),
        .o_data  (w_ent_data),
        .o_valid (w_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_full = (w_count == CW'(DEPTH));

    // Port owner. Reset suppresses everything, including a pending drain.
    always_comb begin
        w_port = PORT_IDLE;
        if (startin)
            w_port = PORT_IDLE;
        else if (MemRead)
            w_port = PORT_LOAD;
        else if (MemWrite && w_full)
            w_port = PORT_FORCED_DRAIN;
        else if (!MemWrite && (w_count != '0))
            w_port = PORT_DRAIN;
    end

    // Walk oldest to youngest so the last match wins (youngest store).
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_head + PW'(k);
            if (w_valid[w_idx] && (w_ent_addr[w_idx][AW-1:OB] == Address[AW-1:OB])) begin
                w_hit = 1'b1;
                w_fwd = w_ent_data[w_idx];
            end
        end
    end

    assign w_deq       = (w_port == PORT_DRAIN) || (w_port == PORT_FORCED_DRAIN);
    assign w_enq       = !startin && MemWrite && !MemRead && !w_full;
    assign Stall       = !startin && MemWrite && !MemRead && w_full;
    assign w_load_data = w_hit ? w_fwd : mem_ReadData;
    assign ReadData    = (w_port == PORT_LOAD) ? w_load_data : r_hold;

    assign mem_MemWrite  = w_deq;
    assign mem_MemRead   = (w_port == PORT_LOAD) && !w_hit;
    assign mem_Address   = w_deq ? w_ent_addr[w_head] : (mem_MemRead ? Address : '0);
    assign mem_WriteData = w_deq ? w_ent_data[w_head] : '0;

    assign Empty = (w_count == '0);
    assign Count = w_count;

    always_ff @(posedge clk) begin
        if (startin)
            r_hold <= '0;
        else if (w_port == PORT_LOAD)
            r_hold <= w_load_data;
    end

    // A simultaneous load and store is a pipeline bug; the store is dropped.
    always_ff @(posedge clk) begin
        if (!startin)
            assert (!(MemRead && MemWrite))
            else $error("store_buffer: MemRead and MemWrite both high, store ignored");
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        startin;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;
    logic [2:0]  Count;
    logic [31:0] mem_Address;
    logic [31:0] mem_WriteData;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_ReadData;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk           (clk),
        .startin       (startin),
        .Address       (Address),
        .WriteData     (WriteData),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .ReadData      (ReadData),
        .Stall         (Stall),
        .Empty         (Empty),
        .Count         (Count),
        .mem_Address   (mem_Address),
        .mem_WriteData (mem_WriteData),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_ReadData  (mem_ReadData)
    );

    // Data memory: combinational read, write at posedge.
    logic [31:0] mem [64];
    logic        mem_init_done = 1'b0;
    assign mem_ReadData = mem[mem_Address[7:2]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[2] = 32'd3;      // 0x08
            mem[9] = 32'h0A;     // 0x24
            mem_init_done = 1'b1;
        end else if (mem_MemWrite) begin
            mem[mem_Address[7:2]] = mem_WriteData;
        end
    end

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic [31:0] rd; logic mr; } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected memory writes and load results as the DUT presents them.
    initial begin
        wr_t we;
        rd_t re;
        forever begin
            @(negedge clk);
            if (mem_MemWrite === 1'b1) begin
                if (wq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                             mem_Address, mem_WriteData);
                end else begin
                    we = wq.pop_front();
                    chk("drain_addr", mem_Address, we.a);
                    chk("drain_data", mem_WriteData, we.d);
                end
            end
            if (MemRead === 1'b1) begin
                if (rq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_load: ReadData 0x%08h, no expectation queued", ReadData);
                end else begin
                    re = rq.pop_front();
                    chk("load_data", ReadData, re.rd);
                    chk("load_memread", 32'(mem_MemRead), 32'(re.mr));
                end
            end
        end
    end

    // Drive one cycle: inputs change #1 after posedge, caller checks at negedge.
    task automatic cyc(input logic st, input logic mw, input logic mr,
                       input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        startin   = st;
        MemWrite  = mw;
        MemRead   = mr;
        Address   = a;
        WriteData = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic load(input logic [31:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        startin = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Address = '0; WriteData = '0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Post-reset state
        idle();
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_readdata", ReadData, 32'h0);
        chk("rst_memwrite", 32'(mem_MemWrite), 32'd0);
        chk("rst_memread", 32'(mem_MemRead), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);

        // Single store, then idle drains it one cycle later
        wq.push_back('{a: 32'h10, d: 32'hDEADBEEF});
        store(32'h10, 32'hDEADBEEF);
        chk("t1_c0_memwrite", 32'(mem_MemWrite), 32'd0);
        chk("t1_c0_stall", 32'(Stall), 32'd0);
        idle();
        chk("t1_c1_memwrite", 32'(mem_MemWrite), 32'd1);
        idle();
        chk("t1_c2_empty", 32'(Empty), 32'd1);

        // Load forwarded from buffer (memory holds 3)
        wq.push_back('{a: 32'h08, d: 32'd5});
        store(32'h08, 32'd5);
        rq.push_back('{rd: 32'd5, mr: 1'b0});
        load(32'h08);
        chk("t2_count", 32'(Count), 32'd1);
        idle();
        idle();
        chk("t2_empty", 32'(Empty), 32'd1);

        // Duplicate address: youngest forwarded, drains in order
        wq.push_back('{a: 32'h0C, d: 32'd1});
        store(32'h0C, 32'd1);
        wq.push_back('{a: 32'h0C, d: 32'd2});
        store(32'h0C, 32'd2);
        rq.push_back('{rd: 32'd2, mr: 1'b0});
        load(32'h0C);
        chk("t3_count", 32'(Count), 32'd2);
        idle();
        idle();
        idle();
        chk("t3_empty", 32'(Empty), 32'd1);

        // Fill, then a store to a full buffer stalls one cycle with a forced drain
        for (int i = 0; i < 4; i++) begin
            wq.push_back('{a: 32'(4 * i), d: 32'(11 + i)});
            store(32'(4 * i), 32'(11 + i));
        end
        store(32'h10, 32'd15);
        chk("t4_full_count", 32'(Count), 32'd4);
        chk("t4_full_stall", 32'(Stall), 32'd1);
        chk("t4_forced_drain", 32'(mem_MemWrite), 32'd1);
        wq.push_back('{a: 32'h10, d: 32'd15});
        store(32'h10, 32'd15);
        chk("t4_accept_stall", 32'(Stall), 32'd0);
        chk("t4_accept_count", 32'(Count), 32'd3);
        idle();
        chk("t4_after_count", 32'(Count), 32'd4);
        idle();
        idle();
        idle();
        idle();
        chk("t4_empty", 32'(Empty), 32'd1);

        // Load miss from memory, then ReadData holds
        rq.push_back('{rd: 32'h0A, mr: 1'b1});
        load(32'h24);
        chk("t5_mem_addr", mem_Address, 32'h24);
        idle();
        chk("t5_hold", ReadData, 32'h0A);
        chk("t5_hold_memread", 32'(mem_MemRead), 32'd0);

        // Reset with pending stores discards them and suppresses the drain
        wq.push_back('{a: 32'h30, d: 32'd7});
        store(32'h30, 32'd7);
        wq.push_back('{a: 32'h34, d: 32'd8});
        store(32'h34, 32'd8);
        wq.push_back('{a: 32'h38, d: 32'd9});
        store(32'h38, 32'd9);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("t6_pending_count", 32'(Count), 32'd3);
        chk("t6_rst_memwrite", 32'(mem_MemWrite), 32'd0);
        chk("t6_rst_stall", 32'(Stall), 32'd0);
        wq.delete();
        idle();
        chk("t6_count", 32'(Count), 32'd0);
        chk("t6_empty", 32'(Empty), 32'd1);
        chk("t6_readdata", ReadData, 32'h0);
        idle();
        idle();
        idle();
        chk("t6_no_write", 32'(mem_MemWrite), 32'd0);

        chk("end_wq_drained", 32'(wq.size()), 32'd0);
        chk("end_rq_drained", 32'(rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
